product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 12, SHALL set the accumulator and result width in bits (legal range 8..32).
REQ-002 Parameter MAX_TERMS, default 16, SHALL set the maximum number of products per group (legal range 1..255).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: prod and in_last are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-007 Port prod, input, 8: unsigned 8-bit product from the upstream 4x4 array multiplier.
REQ-008 Port in_last, input, 1: this beat closes the current group.
REQ-009 Port out_valid, output, 1: result fields are valid.
REQ-010 Port out_ready, input, 1: the downstream stage takes the result.
REQ-011 Port acc_out, output, ACC_W: the group sum.
REQ-012 Port term_cnt, output, 8: the number of products in the group.
REQ-013 Port ovf, output, 1: the group sum exceeded 2^ACC_W-1 at least once.

Function
REQ-014 A beat SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-016 In IDLE, an accepted beat SHALL load acc=prod, cnt=1 and ovf=0, then move to ACCUM, or straight to HOLD if the group closes on that beat.
REQ-017 In ACCUM, each accepted beat SHALL compute acc=acc+prod at ACC_W+1 bits and increment cnt.
REQ-018 A group SHALL close on the accepted beat that has in_last=1, or on the beat that makes cnt equal MAX_TERMS, whichever comes first.
REQ-019 On close, the final sum SHALL be registered into acc_out, term_cnt and ovf, and out_valid SHALL be 1 from the following cycle (latency one cycle from the last accepted beat).
REQ-020 In HOLD, acc_out, term_cnt and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 When out_valid and out_ready are both 1, out_valid SHALL fall at that edge and the FSM SHALL return to IDLE; in_ready SHALL be 1 in the next cycle, giving no same-cycle bypass.
REQ-022 The accumulation carry-out SHALL set ovf, and ovf SHALL stay set until the next group loads.
REQ-023 in_valid=1 while in_ready=0 SHALL be ignored; the upstream stage holds the beat.
REQ-024 prod=0 beats SHALL count as terms.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, acc_out=0, term_cnt=0, ovf=0 and the internal acc and cnt cleared.
REQ-026 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result with no output.
REQ-027 Reset release SHALL be synchronised internally so that the first accept occurs no earlier than the second rising edge after release.

Configuration
REQ-028 With macro PRODUCT_ACCUMULATOR_SAT_EN defined, an overflowing addition SHALL clamp acc to 2^ACC_W-1 and later additions SHALL hold it there.
REQ-029 With PRODUCT_ACCUMULATOR_SAT_EN undefined, the sum SHALL wrap modulo 2^ACC_W; ovf behaviour is identical in both builds.

Structure
REQ-030 The FSM state enum, the state width and the constant PROD_W=8 SHALL live in the shared package prodacc_pkg.
REQ-031 The add, clamp and carry logic SHALL be one sub-module, acc_adder, parameterised by ACC_W and producing the sum and carry-out; the FSM and registers SHALL stay in the top module.

Verification
REQ-032 Bench (defaults) SHALL cover: 4 beats of 225 with in_last on the 4th -> next cycle out_valid=1, acc_out=900, term_cnt=4, ovf=0.
REQ-033 Bench SHALL cover: a single beat prod=49 with in_last=1 in IDLE -> acc_out=49, term_cnt=1 one cycle later.
REQ-034 Bench SHALL cover: 16 beats of 1 with in_last=0 -> the group auto-closes with acc_out=16, term_cnt=16, and the 17th beat starts a new group after the handshake.
REQ-035 Bench (ACC_W=10) SHALL cover: 5 beats of 225 -> ovf=1, with acc_out=1023 when SAT_EN is defined and acc_out=101 when it is undefined.
REQ-036 Bench SHALL cover: out_ready=0 for 3 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable and no beats lost; after out_ready=1, the next group sums correctly.
REQ-037 Bench SHALL cover: rst_n pulsed low after 2 of 4 beats -> no output, and a fresh 2-beat group of 10 and 20 yields acc_out=30.

Source files
------------

// File: rtl/prodacc_pkg.sv
// Shared types and constants for the product accumulator: FSM state encoding and bus widths.
package prodacc_pkg;

    localparam int unsigned PROD_W  = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: acc + prod at ACC_W+1 bits, with carry-out.
// Macro PRODUCT_ACCUMULATOR_SAT_EN clamps an overflowing sum to all-ones instead of wrapping.
module acc_adder
    import prodacc_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_c_o,
    output logic              carry_c_o
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] wide_c;

    assign wide_c    = SUM_W'(acc_i) + SUM_W'(prod_i);
    assign carry_c_o = wide_c[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // A saturated accumulator overflows again on any nonzero product, so it stays clamped.
    assign sum_c_o = carry_c_o ? {ACC_W{1'b1}} : wide_c[ACC_W-1:0];
`else
    assign sum_c_o = wide_c[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Groups a stream of 8-bit products into sums of up to MAX_TERMS terms with a ready/valid result port.
// Optional macro PRODUCT_ACCUMULATOR_SAT_EN selects a saturating accumulator (see acc_adder).
module product_accumulator
    import prodacc_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, sum_c;
    logic [CNT_W-1:0] cnt_q, cnt_d, term_cnt_q, term_cnt_d, cnt_inc_c;
    logic             ovf_q, ovf_d, ovf_out_q, ovf_out_d;
    logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic             carry_c, accept_c, close_c;
    logic [1:0]       rst_sync_q;

    assign accept_c  = in_valid && in_ready_q && rst_sync_q[1];
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_acc_adder (
        .acc_i     (acc_q),
        .prod_i    (prod),
        .sum_c_o   (sum_c),
        .carry_c_o (carry_c)
    );

    // Reset-release synchroniser: beats are only taken once the release has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            term_cnt_q  <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            term_cnt_q  <= term_cnt_d;
            ovf_out_q   <= ovf_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        term_cnt_d  = term_cnt_q;
        ovf_out_d   = ovf_out_q;
        out_valid_d = out_valid_q;
        close_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    acc_d   = ACC_W'(prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                    close_c = in_last || (CNT_W'(MAX_TERMS) == CNT_W'(1));
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    acc_d   = sum_c;
                    cnt_d   = cnt_inc_c;
                    ovf_d   = ovf_q || carry_c;
                    close_c = in_last || (cnt_inc_c == CNT_W'(MAX_TERMS));
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Closing beat: publish the just-computed group result next cycle.
        if (close_c) begin
            state_d     = ST_HOLD;
            acc_out_d   = acc_d;
            term_cnt_d  = cnt_d;
            ovf_out_d   = ovf_d;
            out_valid_d = 1'b1;
        end

        in_ready_d = (state_d != ST_HOLD);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign term_cnt  = term_cnt_q;
    assign ovf       = ovf_out_q;

endmodule
